modbus_rsp_parser: RTL and testbench
====================================

// Module: modbus_rsp_parser
// PURPOSE
//  Receive-side Modbus RTU frame parser for the single-slave master. Consumes UART
//  bytes, delimits frames by the 3.5-char silence gap and checks CRC16. Parses
//  function-0x03 read-holding-register responses. Drives the register demux
//  directly downstream (adr, n_data, data_in, data_strb, crc_validate).
// PARAMETERS
//  T35_CYCLES  4010   clk cycles of line silence that close/delimit a frame
//  MAX_REGS    30     max registers per response; must equal demux number_of_reg
//  FUNC_CODE   8'h03  accepted function code
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high
//  rx_byte       in   8   received UART byte
//  rx_valid      in   1   1-cycle pulse, rx_byte valid
//  rx_err        in   1   1-cycle pulse, UART framing/parity error
//  adr           out  8   slave address of current frame
//  n_data        out  8   register index, 1-based (register k of frame -> k)
//  data_in       out  16  register value {hi,lo}
//  data_strb     out  1   1-cycle pulse, new adr/n_data/data_in valid
//  crc_validate  out  1   high during commit sweep only
//  frame_err     out  1   1-cycle pulse: CRC mismatch, bad byte count, rx_err, truncation
//  busy          out  1   high from first byte of a frame until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> WAIT_GAP; gap counter 0; CRC reg 16'hFFFF.
//  Gap counter: cleared on rx_valid, otherwise increments, saturating at T35_CYCLES.
//   gap_hit = (count == T35_CYCLES-1 and incrementing).
//  FSM states: WAIT_GAP, IDLE, FUNC, BCNT, DATA_HI, DATA_LO, CRC_LO, CRC_HI,
//   COMMIT, DROP.
//   WAIT_GAP: gap_hit -> IDLE; bytes restart the counter.
//   IDLE: byte -> adr, CRC init+update, -> FUNC.
//   FUNC: byte==FUNC_CODE -> BCNT; else -> DROP.
//   BCNT: even, nonzero, <= 2*MAX_REGS -> DATA_HI, reg index k=1; else -> DROP.
//   DATA_HI: latch hi -> DATA_LO.
//   DATA_LO: next cycle data_in={hi,lo}, n_data=k, data_strb=1 for one cycle.
//    Last pair -> CRC_LO, else k++ -> DATA_HI.
//   CRC_LO/CRC_HI: received CRC, low byte first.
//    Match -> COMMIT; mismatch -> frame_err, -> WAIT_GAP.
//   COMMIT: crc_validate=1 for exactly nregs+1 cycles, n_data=1,2..nregs then
//    nregs held. Matches the demux's 1-cycle registered read. Non-interruptible.
//    Then -> WAIT_GAP.
//   DROP: ignore bytes until gap_hit -> IDLE.
//  CRC: Modbus CRC16, init FFFF, reflected poly A001.
//   Covers address..last data byte; updated in the same cycle as byte acceptance.
//  Priority/corners:
//   - reset > gap_hit > rx_err > rx_valid.
//   - gap_hit in FUNC..CRC_HI (truncated frame): frame_err, -> IDLE.
//   - gap_hit and rx_valid in the same cycle: old frame closes, byte starts a new
//     frame (address).
//   - rx_err in any frame state: frame_err, -> DROP.
//   - Bytes arriving in COMMIT are ignored and restart the gap counter.
//   - adr, n_data and data_in hold their last value between strobes; never return
//     to 0 except on reset.
//   - reset mid-frame: no strobe or commit is emitted.
// CONFIGURATION
//  MB_EXCEPTION_EN defined: FUNC byte == FUNC_CODE|8'h80 -> EXC -> CRC_LO/CRC_HI.
//   On CRC match: ports exc_valid (out,1, 1-cycle pulse) and exc_code (out,8, held
//   until next exception) are driven; no COMMIT.
//  Undefined: exc_* ports absent; exception frames -> DROP, frame_err pulses.
// STRUCTURE
//  Package mb_rtu_pkg: FSM state enum; CRC_INIT=16'hFFFF; CRC_POLY=16'hA001;
//   FUNC_READ_HOLD=8'h03; EXC_FLAG=8'h80.
//  Sub-module mb_crc16: registered CRC with init/update enables, 8-bit combinational
//   byte step; crc output.
// TESTING
//  T1: gap, then 01 03 04 12 34 AB CD + good CRC ->
//   data_strb n_data=1 data_in=1234; n_data=2 data_in=ABCD; adr=01;
//   crc_validate 3 cycles with n_data 1,2,2.
//  T2: same frame with CRC lo byte ^01 -> two data_strb pulses, frame_err 1 pulse,
//   crc_validate never high.
//  T3: byte count 0x3E (31 regs, MAX_REGS=30) -> frame_err, no data_strb,
//   next good frame after gap parses.
//  T4: frame cut after DATA_HI of reg 2, silence T35_CYCLES -> frame_err on gap_hit;
//   following full frame with no extra gap accepted.
//  T5: byte at T35_CYCLES-2 cycles after previous frame end -> ignored (WAIT_GAP
//   restarts), no outputs.
//  T6 (MB_EXCEPTION_EN): 01 83 02 + good CRC -> exc_valid pulse, exc_code=02,
//   no crc_validate; undefined -> frame_err.

Source files
------------

// File: rtl/mb_rtu_pkg.sv
// mb_rtu_pkg: shared FSM states and Modbus RTU constants for the response parser
package mb_rtu_pkg;
  typedef enum logic [3:0] {
    WAIT_GAP, IDLE, FUNC, BCNT, DATA_HI, DATA_LO, CRC_LO, CRC_HI, COMMIT, DROP, EXC
  } state_t;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [7:0] FUNC_READ_HOLD = 8'h03;
  localparam logic [7:0] EXC_FLAG = 8'h80;
endpackage

// File: rtl/mb_crc16.sv
// mb_crc16: registered Modbus CRC16 with init/update enables and a one-byte combinational step
module mb_crc16
  import mb_rtu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        upd,
  input  logic [7:0]  data,
  output logic [15:0] crc
);
  logic [15:0] nxt;
  always_comb begin
    nxt = (init ? CRC_INIT : crc) ^ {8'h00, data};
    for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ CRC_POLY : nxt >> 1;
  end
  always_ff @(posedge clk) begin
    if (reset) crc <= CRC_INIT;
    else if (init || upd) crc <= nxt;
  end
endmodule

// File: rtl/modbus_rsp_parser.sv
// modbus_rsp_parser: Modbus RTU read-holding-register response parser; MB_EXCEPTION_EN adds exception reporting
module modbus_rsp_parser
  import mb_rtu_pkg::*;
#(
  parameter int         T35_CYCLES = 4010,
  parameter int         MAX_REGS   = 30,
  parameter logic [7:0] FUNC_CODE  = FUNC_READ_HOLD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [7:0]  adr,
  output logic [7:0]  n_data,
  output logic [15:0] data_in,
  output logic        data_strb,
  output logic        crc_validate,
  output logic        frame_err,
`ifdef MB_EXCEPTION_EN
  output logic        exc_valid,
  output logic [7:0]  exc_code,
`endif
  output logic        busy
);
`ifdef MB_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam int CW = $clog2(T35_CYCLES + 1);
  localparam logic [8:0] BMAX = 9'(2 * MAX_REGS);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [7:0] hi, crc_lo, k, nregs, cc;
  logic [15:0] crc;
  logic gap_hit, gap, acc, start, step, in_frame, bc_ok, crc_ok, exc_fc, is_exc, upd, err_d;
  assign gap_hit  = cnt == CW'(T35_CYCLES - 1);
  assign acc      = rx_valid & ~rx_err;
  assign gap      = gap_hit & (state != COMMIT);
  // a byte coinciding with the closing gap opens the next frame
  assign start    = acc & (gap | (state == IDLE));
  assign step     = acc & ~gap & (state != IDLE);
  assign in_frame = state inside {FUNC, BCNT, DATA_HI, DATA_LO, CRC_LO, CRC_HI, EXC};
  assign bc_ok    = (rx_byte != 8'd0) && !rx_byte[0] && ({1'b0, rx_byte} <= BMAX);
  assign crc_ok   = {rx_byte, crc_lo} == crc;
  assign exc_fc   = rx_byte == (FUNC_CODE | EXC_FLAG);
  assign upd      = step & (state inside {FUNC, BCNT, DATA_HI, DATA_LO, EXC});
  mb_crc16 u_crc (.clk(clk), .reset(reset), .init(start), .upd(upd), .data(rx_byte), .crc(crc));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_GAP;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= rx_valid ? '0 : (cnt == CW'(T35_CYCLES)) ? cnt : cnt + CW'(1);
    end
  end
  always_comb begin
    nxt = state;
    if (state == COMMIT) nxt = (cc == nregs + 8'd1) ? WAIT_GAP : COMMIT;
    else if (start) nxt = FUNC;
    else if (gap) nxt = IDLE;
    else if (rx_err && in_frame) nxt = DROP;
    else if (step)
      case (state)
        FUNC:    nxt = (rx_byte == FUNC_CODE) ? BCNT : (EXC_EN && exc_fc) ? EXC : DROP;
        BCNT:    nxt = bc_ok ? DATA_HI : DROP;
        DATA_HI: nxt = DATA_LO;
        DATA_LO: nxt = (k == nregs) ? CRC_LO : DATA_HI;
        EXC:     nxt = CRC_LO;
        CRC_LO:  nxt = CRC_HI;
        CRC_HI:  nxt = (crc_ok && !is_exc) ? COMMIT : WAIT_GAP;
        default: nxt = state;
      endcase
  end
  always_comb begin
    crc_validate = state == COMMIT;
    err_d = (in_frame && (gap || rx_err)) ||
            (step && ((state == BCNT && !bc_ok) || (state == CRC_HI && !crc_ok) ||
                      (state == FUNC && !EXC_EN && exc_fc)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      adr <= '0;
      n_data <= '0;
      data_in <= '0;
      data_strb <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
      hi <= '0;
      crc_lo <= '0;
      k <= '0;
      nregs <= '0;
      cc <= '0;
      is_exc <= 1'b0;
    end else begin
      data_strb <= step && state == DATA_LO;
      frame_err <= err_d;
      busy <= (nxt == IDLE) ? 1'b0 : (start | busy);
      if (start) adr <= rx_byte;
      if (step && state == FUNC) is_exc <= exc_fc;
      if (step && state == BCNT) begin
        nregs <= {1'b0, rx_byte[7:1]};
        k <= 8'd1;
      end
      if (step && state == DATA_HI) hi <= rx_byte;
      if (step && state == DATA_LO) begin
        data_in <= {hi, rx_byte};
        n_data <= k;
        k <= k + 8'd1;
      end
      if (step && state == CRC_LO) crc_lo <= rx_byte;
      // commit sweep runs one cycle past nregs to cover the demux's registered read
      if (nxt == COMMIT && state != COMMIT) begin
        n_data <= 8'd1;
        cc <= 8'd1;
      end else if (state == COMMIT) begin
        cc <= cc + 8'd1;
        n_data <= (cc >= nregs) ? nregs : cc + 8'd1;
      end
    end
  end
`ifdef MB_EXCEPTION_EN
  logic [7:0] exc_tmp;
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_valid <= 1'b0;
      exc_code <= '0;
      exc_tmp <= '0;
    end else begin
      exc_valid <= step && state == CRC_HI && crc_ok && is_exc;
      if (step && state == EXC) exc_tmp <= rx_byte;
      if (step && state == CRC_HI && crc_ok && is_exc) exc_code <= exc_tmp;
    end
  end
`endif
endmodule

// File: tb/tb_modbus_rsp_parser.sv
// tb_modbus_rsp_parser: table-driven, hand-written and randomized checks of the Modbus response parser
`timescale 1ns/1ps
module tb_modbus_rsp_parser;
  localparam int T35 = 64;
  localparam int MAXR = 30;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b[8];
    int len;
    bit crc;
    bit bad;
    int e_strb;
    int e_err;
    int e_com;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, rx_valid = 1'b0, rx_err = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] adr, n_data;
  logic [15:0] data_in;
  logic data_strb, crc_validate, frame_err, busy;
`ifdef MB_EXCEPTION_EN
  logic exc_valid;
  logic [7:0] exc_code;
`endif
  int n_chk = 0, n_fail = 0, err_cnt = 0, exc_cnt = 0;
  logic [7:0] s_n[$], s_a[$], c_n[$];
  logic [15:0] s_d[$];
  modbus_rsp_parser #(.T35_CYCLES(T35), .MAX_REGS(MAXR)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .adr(adr), .n_data(n_data), .data_in(data_in), .data_strb(data_strb),
    .crc_validate(crc_validate), .frame_err(frame_err),
`ifdef MB_EXCEPTION_EN
    .exc_valid(exc_valid), .exc_code(exc_code),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (!reset) begin
    if (data_strb) begin
      s_n.push_back(n_data);
      s_d.push_back(data_in);
      s_a.push_back(adr);
    end
    if (frame_err) err_cnt++;
    if (crc_validate) c_n.push_back(n_data);
`ifdef MB_EXCEPTION_EN
    if (exc_valid) exc_cnt++;
`endif
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_frame(input bq_t q);
    foreach (q[i]) begin
      send(q[i]);
      if (i != q.size() - 1) idle(2);
    end
  endtask
  task automatic clear();
    s_n.delete();
    s_d.delete();
    s_a.delete();
    c_n.delete();
    err_cnt = 0;
    exc_cnt = 0;
  endtask
  function automatic logic [15:0] mb_crc(input bq_t q, input int n);
    int c = 'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ int'(q[i]);
      for (int j = 0; j < 8; j++) c = (c % 2 == 1) ? (c / 2) ^ 'hA001 : c / 2;
    end
    return 16'(c);
  endfunction
  task automatic add_crc(inout bq_t q, input bit bad);
    logic [15:0] c = mb_crc(q, q.size());
    if (bad) c[0] = ~c[0];
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
  endtask
  // frame-level prediction: complete register pairs strobed, one error per broken frame, nregs+1 commit cycles
  task automatic model(input bq_t q, output int pairs, output int e_err, output int e_com);
    int len = q.size();
    int nr;
    pairs = 0;
    e_err = 0;
    e_com = 0;
    if (len == 0) return;
    if (len >= 2 && q[1] != 8'h03) return;
    if (len < 3) begin
      e_err = 1;
      return;
    end
    if (q[2] == 8'h00 || q[2][0] || int'(q[2]) > 2 * MAXR) begin
      e_err = 1;
      return;
    end
    nr = int'(q[2]) / 2;
    pairs = (len - 3) / 2 > nr ? nr : (len - 3) / 2;
    if (len < 5 + 2 * nr) e_err = 1;
    else if ({q[4 + 2 * nr], q[3 + 2 * nr]} == mb_crc(q, 3 + 2 * nr)) e_com = nr + 1;
    else e_err = 1;
  endtask
  task automatic check_logs(input string nm, input bq_t q, input int pairs, input int e_err, input int e_com);
    chk({nm, " strb_cnt"}, 32'(s_n.size()), 32'(pairs));
    for (int i = 0; i < pairs && i < s_n.size(); i++) begin
      chk({nm, " strb_n"}, 32'(s_n[i]), 32'(i + 1));
      chk({nm, " strb_data"}, 32'(s_d[i]), 32'({q[3 + 2 * i], q[4 + 2 * i]}));
      chk({nm, " strb_adr"}, 32'(s_a[i]), 32'(q[0]));
    end
    chk({nm, " frame_err_cnt"}, 32'(err_cnt), 32'(e_err));
    chk({nm, " commit_len"}, 32'(c_n.size()), 32'(e_com));
    for (int i = 0; i < e_com && i < c_n.size(); i++)
      chk({nm, " commit_n"}, 32'(c_n[i]), 32'((i < e_com - 1) ? i + 1 : e_com - 1));
    chk({nm, " busy_idle"}, 32'(busy), 32'd0);
  endtask
  task automatic run_table();
    vec_t v[$];
    v.push_back('{'{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00}, 7, 1'b1, 1'b0, 2, 0, 3});
    v.push_back('{'{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00}, 7, 1'b1, 1'b1, 2, 1, 0});
    v.push_back('{'{8'h01, 8'h03, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 1'b0, 0, 1, 0});
    v.push_back('{'{8'h05, 8'h03, 8'h02, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h00}, 5, 1'b1, 1'b0, 1, 0, 2});
    v.push_back('{'{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 1'b0, 0, 1, 0});
    v.push_back('{'{8'h01, 8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b0, 1'b0, 0, 1, 0});
    v.push_back('{'{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4, 1'b1, 1'b0, 0, 0, 0});
`ifdef MB_EXCEPTION_EN
    v.push_back('{'{8'h01, 8'h83, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 1'b0, 0, 0, 0});
`else
    v.push_back('{'{8'h01, 8'h83, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 1'b1, 1'b0, 0, 1, 0});
`endif
    v.push_back('{'{8'h01, 8'h03, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 1'b0, 1'b0, 1, 1, 0});
    foreach (v[n]) begin
      bq_t q;
      for (int i = 0; i < v[n].len; i++) q.push_back(v[n].b[i]);
      if (v[n].crc) add_crc(q, v[n].bad);
      clear();
      send_frame(q);
      idle(T35 + 40);
      check_logs($sformatf("vec%0d", n), q, v[n].e_strb, v[n].e_err, v[n].e_com);
`ifdef MB_EXCEPTION_EN
      if (q[1] == 8'h83) begin
        chk("exc_cnt", 32'(exc_cnt), 32'd1);
        chk("exc_code", 32'(exc_code), 32'h02);
      end
`endif
    end
  endtask
  task automatic run_hand();
    bq_t t1 = '{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD};
    bq_t cut = '{8'h01, 8'h03, 8'h04, 8'h12, 8'h34, 8'hAB};
    bq_t part = '{8'h01, 8'h03, 8'h04, 8'h12};
    bq_t tail = '{8'h34, 8'hAB, 8'hCD};
    bq_t g = t1;
    add_crc(g, 1'b0);
    tail.push_back(g[7]);
    tail.push_back(g[8]);
    clear();
    send_frame(g);
    idle(T35 + 40);
    chk("hold_adr", 32'(adr), 32'h01);
    chk("hold_n_data", 32'(n_data), 32'd2);
    chk("hold_data_in", 32'(data_in), 32'hABCD);
    clear();
    send_frame(cut);
    idle(T35);
    send_frame(g);
    idle(T35 + 40);
    chk("trunc err", 32'(err_cnt), 32'd1);
    chk("trunc strb_cnt", 32'(s_n.size()), 32'd3);
    if (s_d.size() == 3) chk("trunc last_data", 32'(s_d[2]), 32'hABCD);
    chk("trunc commit_len", 32'(c_n.size()), 32'd3);
    clear();
    send_frame(g);
    idle(T35 - 3);
    send_frame(g);
    idle(T35 + 40);
    check_logs("early_byte", g, 2, 0, 3);
    clear();
    send_frame(part);
    idle(T35 - 1);
    send_frame(g);
    idle(T35 + 40);
    chk("gap_and_byte err", 32'(err_cnt), 32'd1);
    check_logs("gap_and_byte", g, 2, 1, 3);
    clear();
    send_frame(part);
    idle(2);
    chk("busy_mid", 32'(busy), 32'd1);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    idle(2);
    send_frame(tail);
    idle(T35 + 40);
    check_logs("rx_err", g, 0, 1, 0);
    clear();
    send_frame(part);
    idle(1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_reset adr", 32'(adr), 32'd0);
    send_frame(tail);
    idle(T35 + 40);
    check_logs("mid_reset", g, 0, 0, 0);
    chk("mid_reset adr_held", 32'(adr), 32'd0);
  endtask
  task automatic run_random();
    for (int r = 0; r < 16; r++) begin
      bq_t q;
      int nr = (r == 0) ? MAXR : $urandom_range(1, MAXR);
      int mode = (r == 0) ? 0 : $urandom_range(0, 3);
      int pairs, e_err, e_com;
      q.push_back(8'($urandom_range(0, 255)));
      q.push_back(8'h03);
      if (mode == 3) q.push_back($urandom_range(0, 1) ? 8'(2 * nr - 1) : 8'(2 * MAXR + 2 * $urandom_range(1, 20)));
      else q.push_back(8'(2 * nr));
      for (int i = 0; i < 2 * nr; i++) q.push_back(8'($urandom_range(0, 255)));
      begin
        logic [15:0] c = mb_crc(q, q.size());
        if (mode == 1) c = c ^ 16'(1 << $urandom_range(0, 15));
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
      end
      if (mode == 2) begin
        int cut = $urandom_range(1, q.size() - 1);
        while (q.size() > cut) void'(q.pop_back());
      end
      model(q, pairs, e_err, e_com);
      clear();
      send_frame(q);
      idle(T35 + 40);
      check_logs($sformatf("rand%0d", r), q, pairs, e_err, e_com);
    end
  endtask
  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst adr", 32'(adr), 32'd0);
    chk("rst n_data", 32'(n_data), 32'd0);
    chk("rst data_in", 32'(data_in), 32'd0);
    chk("rst data_strb", 32'(data_strb), 32'd0);
    chk("rst crc_validate", 32'(crc_validate), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    idle(T35 + 5);
    run_table();
    run_hand();
    run_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
